// File: rtl/le_write_addr_gen_pkg.sv
// rtl/le_write_addr_gen_pkg.sv - shared widths, maximum block size and FSM state type for the Le write-address path
package le_write_addr_gen_pkg;

    localparam int LE_DATA_ADDR_W = 13;
    localparam int LE_WIN_LEN_W   = 7;
    localparam int LE_MAX_K       = 6144;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } le_wag_state_e;

endpackage

// File: rtl/le_write_addr_gen_qpp_mod_add.sv
// rtl/le_write_addr_gen_qpp_mod_add.sv - combinational (x + y) mod K for operands already below K
module qpp_mod_add #(
    parameter int W = 13
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] k_i,
    output logic [W-1:0] sum_o
);

    logic [W:0] sum_full;
    logic       wrap;

    assign sum_full = {1'b0, x_i} + {1'b0, y_i};
    assign wrap     = (sum_full >= {1'b0, k_i});

    // The reduced result is always below K, so W-bit wraparound arithmetic is exact.
    assign sum_o = wrap ? (x_i + y_i - k_i) : (x_i + y_i);

endmodule

// File: rtl/le_write_addr_gen.sv
// rtl/le_write_addr_gen.sv - per-window natural / QPP-interleaved write-address generator for the Le buffer
module le_write_addr_gen
    import le_write_addr_gen_pkg::*;
#(
    parameter int DATA_ADDR_W = LE_DATA_ADDR_W,
    parameter int WIN_LEN_W   = LE_WIN_LEN_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   win_start,
    input  logic [WIN_LEN_W-1:0]   win_len,
    input  logic                   il_mode,
    input  logic [DATA_ADDR_W-1:0] blockSize,
    input  logic [DATA_ADDR_W-1:0] f2x2,
    input  logic [DATA_ADDR_W-1:0] Le_A_init,
    input  logic [DATA_ADDR_W-1:0] Le_Rf_init,
    input  logic [DATA_ADDR_W-1:0] Le_Rg_init,
    input  logic                   stall,
    output logic                   wr_en,
    output logic [DATA_ADDR_W-1:0] wr_addr,
    output logic                   win_done,
    output logic                   busy,
    output logic                   overlap_err
);

    le_wag_state_e          state_q, state_d;
    logic [WIN_LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_ADDR_W-1:0] a_q, a_d, r_q, r_d, g_q, g_d;
    logic                   il_q, il_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                   win_done_q, win_done_d;
    logic                   busy_q, busy_d;
    logic                   overlap_q, overlap_d;

    logic                   load, err, active, emit, last;
    logic [WIN_LEN_W-1:0]   src_cnt;
    logic [DATA_ADDR_W-1:0] src_a, src_r, src_g, r_sum, g_sum;
    logic                   src_il;

    // A freshly loaded window feeds the adders directly, so its first address leaves on the load edge.
    assign load    = win_start && (state_q == S_IDLE);
    assign err     = win_start && (state_q == S_RUN);
    assign src_a   = load ? Le_A_init  : a_q;
    assign src_r   = load ? Le_Rf_init : r_q;
    assign src_g   = load ? Le_Rg_init : g_q;
    assign src_cnt = load ? win_len    : cnt_q;
    assign src_il  = load ? il_mode    : il_q;
    assign active  = (load || (state_q == S_RUN)) && (src_cnt != '0);
    assign emit    = active && !stall;
    assign last    = (src_cnt == WIN_LEN_W'(1));

    qpp_mod_add #(.W(DATA_ADDR_W)) u_r_add (
        .x_i   (src_r),
        .y_i   (src_g),
        .k_i   (blockSize),
        .sum_o (r_sum)
    );

    qpp_mod_add #(.W(DATA_ADDR_W)) u_g_add (
        .x_i   (src_g),
        .y_i   (f2x2),
        .k_i   (blockSize),
        .sum_o (g_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        r_d        = r_q;
        g_d        = g_q;
        il_d       = il_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        win_done_d = 1'b0;
        overlap_d  = overlap_q | err;

        if (emit) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = src_il ? src_r : src_a;
            a_d        = src_a + DATA_ADDR_W'(1);
            r_d        = r_sum;
            g_d        = g_sum;
            il_d       = src_il;
            cnt_d      = src_cnt - WIN_LEN_W'(1);
            win_done_d = last;
            state_d    = last ? S_IDLE : S_RUN;
        end else if (active) begin
            // Start accepted under stall: park the init values until the memory frees up.
            a_d     = src_a;
            r_d     = src_r;
            g_d     = src_g;
            il_d    = src_il;
            cnt_d   = src_cnt;
            state_d = S_RUN;
        end else if (load) begin
            win_done_d = 1'b1;
        end

        busy_d = (state_d == S_RUN) || (emit && last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            r_q        <= '0;
            g_q        <= '0;
            il_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            win_done_q <= 1'b0;
            busy_q     <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            r_q        <= r_d;
            g_q        <= g_d;
            il_q       <= il_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            win_done_q <= win_done_d;
            busy_q     <= busy_d;
            overlap_q  <= overlap_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign win_done    = win_done_q;
    assign busy        = busy_q;
    assign overlap_err = overlap_q;

endmodule

// File: tb/tb_le_write_addr_gen.sv
// tb/tb_le_write_addr_gen.sv - directed self-checking bench for le_write_addr_gen
module tb_le_write_addr_gen;

    logic        clk;
    logic        reset;
    logic        win_start;
    logic [6:0]  win_len;
    logic        il_mode;
    logic [12:0] blockSize;
    logic [12:0] f2x2;
    logic [12:0] Le_A_init;
    logic [12:0] Le_Rf_init;
    logic [12:0] Le_Rg_init;
    logic        stall;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic        win_done;
    logic        busy;
    logic        overlap_err;

    int n_cmp = 0;
    int n_err = 0;

    le_write_addr_gen dut (
        .clk         (clk),
        .reset       (reset),
        .win_start   (win_start),
        .win_len     (win_len),
        .il_mode     (il_mode),
        .blockSize   (blockSize),
        .f2x2        (f2x2),
        .Le_A_init   (Le_A_init),
        .Le_Rf_init  (Le_Rf_init),
        .Le_Rg_init  (Le_Rg_init),
        .stall       (stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .win_done    (win_done),
        .busy        (busy),
        .overlap_err (overlap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [12:0] addr,
                             input logic done, input logic bsy);
        chk_bit({tag, "_wr_en"}, wr_en, en);
        chk_addr({tag, "_wr_addr"}, wr_addr, addr);
        chk_bit({tag, "_win_done"}, win_done, done);
        chk_bit({tag, "_busy"}, busy, bsy);
    endtask

    task automatic start_win(input logic [12:0] a, input logic [12:0] rf, input logic [12:0] rg,
                             input logic [6:0] len, input logic il);
        Le_A_init  = a;
        Le_Rf_init = rf;
        Le_Rg_init = rg;
        win_len    = len;
        il_mode    = il;
        win_start  = 1'b1;
    endtask

    logic [12:0] il40 [5];
    logic [12:0] big  [3];

    initial begin
        il40[0] = 13'd0;  il40[1] = 13'd13; il40[2] = 13'd6;
        il40[3] = 13'd19; il40[4] = 13'd12;
        big[0] = 13'd6143; big[1] = 13'd6142; big[2] = 13'd6140;

        reset = 1'b0; win_start = 1'b0; win_len = '0; il_mode = 1'b0; stall = 1'b0;
        blockSize = '0; f2x2 = '0; Le_A_init = '0; Le_Rf_init = '0; Le_Rg_init = '0;
        tick(); tick();
        check_out("reset", 1'b0, 13'd0, 1'b0, 1'b0);
        chk_bit("reset_overlap", overlap_err, 1'b0);
        reset = 1'b1;
        blockSize = 13'd40; f2x2 = 13'd20;
        tick();

        // Interleaved K=40 window
        start_win(13'd999, 13'd0, 13'd13, 7'd5, 1'b1);
        tick(); win_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("il%0d", i), 1'b1, il40[i], (i == 4), 1'b1);
            tick();
        end
        check_out("il_idle", 1'b0, 13'd12, 1'b0, 1'b0);

        // Natural window with back-to-back successor launched on its last address
        start_win(13'd100, 13'd0, 13'd0, 7'd4, 1'b0);
        tick(); win_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("nat%0d", i), 1'b1, 13'd100 + 13'(i), (i == 3), 1'b1);
            if (i == 3) start_win(13'd200, 13'd0, 13'd0, 7'd2, 1'b0);
            tick();
            win_start = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            check_out($sformatf("b2b%0d", i), 1'b1, 13'd200 + 13'(i), (i == 1), 1'b1);
            tick();
        end
        check_out("b2b_idle", 1'b0, 13'd201, 1'b0, 1'b0);
        chk_bit("b2b_overlap", overlap_err, 1'b0);

        // Stall for three cycles after the second interleaved address
        start_win(13'd0, 13'd0, 13'd13, 7'd5, 1'b1);
        tick(); win_start = 1'b0;
        check_out("st0", 1'b1, 13'd0, 1'b0, 1'b1);
        tick();
        check_out("st1", 1'b1, 13'd13, 1'b0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("st_hold%0d", i), 1'b0, 13'd13, 1'b0, 1'b1);
        end
        stall = 1'b0;
        for (int i = 2; i < 5; i++) begin
            tick();
            check_out($sformatf("st%0d", i), 1'b1, il40[i], (i == 4), 1'b1);
        end
        tick();
        check_out("st_idle", 1'b0, 13'd12, 1'b0, 1'b0);

        // Zero-length window
        start_win(13'd50, 13'd0, 13'd0, 7'd0, 1'b0);
        tick(); win_start = 1'b0;
        check_out("len0", 1'b0, 13'd12, 1'b1, 1'b0);
        tick();
        check_out("len0_after", 1'b0, 13'd12, 1'b0, 1'b0);

        // Start in the second cycle of a running window is ignored and flagged
        start_win(13'd300, 13'd0, 13'd0, 7'd4, 1'b0);
        tick(); win_start = 1'b0;
        check_out("ov0", 1'b1, 13'd300, 1'b0, 1'b1);
        tick();
        check_out("ov1", 1'b1, 13'd301, 1'b0, 1'b1);
        start_win(13'd500, 13'd0, 13'd0, 7'd2, 1'b0);
        tick(); win_start = 1'b0;
        check_out("ov2", 1'b1, 13'd302, 1'b0, 1'b1);
        chk_bit("ov2_overlap", overlap_err, 1'b1);
        tick();
        check_out("ov3", 1'b1, 13'd303, 1'b1, 1'b1);
        tick();
        check_out("ov_idle", 1'b0, 13'd303, 1'b0, 1'b0);
        chk_bit("ov_sticky", overlap_err, 1'b1);

        // K=6144 with R and G at K-1
        blockSize = 13'd6144; f2x2 = 13'd6143;
        start_win(13'd0, 13'd6143, 13'd6143, 7'd3, 1'b1);
        tick(); win_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("bigk%0d", i), 1'b1, big[i], (i == 2), 1'b1);
            tick();
        end
        check_out("bigk_idle", 1'b0, 13'd6140, 1'b0, 1'b0);

        // Reset in the middle of a 64-long window
        start_win(13'd0, 13'd0, 13'd0, 7'd64, 1'b0);
        tick(); win_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_out("long9", 1'b1, 13'd9, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_out("midrst", 1'b0, 13'd0, 1'b0, 1'b0);
        chk_bit("midrst_overlap", overlap_err, 1'b0);
        tick();
        check_out("midrst_hold", 1'b0, 13'd0, 1'b0, 1'b0);
        reset = 1'b1;
        blockSize = 13'd40; f2x2 = 13'd20;
        tick();
        check_out("post_rst_idle", 1'b0, 13'd0, 1'b0, 1'b0);

        start_win(13'd999, 13'd0, 13'd13, 7'd5, 1'b1);
        tick(); win_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("re_il%0d", i), 1'b1, il40[i], (i == 4), 1'b1);
            tick();
        end
        check_out("re_idle", 1'b0, 13'd12, 1'b0, 1'b0);
        chk_bit("re_overlap", overlap_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/le_write_addr_gen.md
# le_write_addr_gen

Per-window write-address generator for the extrinsic (Le) soft/hard output buffer of the turbo decoder. It consumes the per-window initial address set produced by the Le init-address save stage: natural start address `A`, interleaved start `Rf`, and interleaver increment `Rg`. From these it emits one buffer write address per cycle for every LLR the SISO core produces in that window. It sits between the init-address save stage and the Le memory write port, and serves both half-iterations: natural order for decoder 1, QPP-interleaved order for decoder 2.

## Interface
- `DATA_ADDR_W`, default 13: address width; holds the block size K up to 6144.
- `WIN_LEN_W`, default 7: width of the window-length field (windows up to 64).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `win_start`  in  1  single-cycle pulse; window init values valid.
- `win_len`  in  `WIN_LEN_W`  number of addresses in this window, 0..64.
- `il_mode`  in  1  0 = natural order, 1 = interleaved order; sampled at `win_start`.
- `blockSize`  in  `DATA_ADDR_W`  K; static during a block.
- `f2x2`  in  `DATA_ADDR_W`  (2·f2) mod K; static during a block.
- `Le_A_init`  in  `DATA_ADDR_W`  natural start address.
- `Le_Rf_init`  in  `DATA_ADDR_W`  Π(i0), the interleaved start address; < K.
- `Le_Rg_init`  in  `DATA_ADDR_W`  g(i0) = (f1 + f2 + 2·f2·i0) mod K; < K.
- `stall`  in  1  Le memory not ready; freezes the generator.
- `wr_en`  out  1  write strobe.
- `wr_addr`  out  `DATA_ADDR_W`  Le buffer write address.
- `win_done`  out  1  pulse coincident with the last address of the window.
- `busy`  out  1  a window is in progress.
- `overlap_err`  out  1  sticky; a `win_start` arrived while busy and not on the last address.

## Operation
- States: IDLE, RUN.
- IDLE + `win_start`, `win_len` > 0: load counter ← `win_len`, A ← `Le_A_init`, R ← `Le_Rf_init`, G ← `Le_Rg_init`, latch `il_mode`; go to RUN.
- IDLE + `win_start`, `win_len` = 0: stay in IDLE; pulse `win_done` next cycle with `wr_en` = 0.
- RUN, `stall` = 0, each cycle:
  - Drive `wr_en` = 1.
  - `wr_addr` = A in natural mode, R in interleaved mode.
  - Update A ← A + 1, R ← modadd(R, G), G ← modadd(G, `f2x2`), counter ← counter − 1.
- modadd(x, y): s = x + y computed at `DATA_ADDR_W`+1 bits; result = s − K if s ≥ K, else s. Both operands are < K, so a single conditional subtract is sufficient.
- Natural mode: A is not wrapped. The upstream stage guarantees A + `win_len` ≤ K.
- Last address, i.e. counter = 1 and not stalled:
  - Assert `win_done`.
  - If `win_start` is present in that same cycle, reload and stay in RUN with no bubble.
  - Otherwise return to IDLE.
- `win_start` in RUN but not on the last address: ignored, and `overlap_err` is set. `overlap_err` is cleared only by reset.
- `stall` = 1: `wr_en` = 0; all state, counter and `wr_addr` are held. A `win_start` arriving during a stall on the last address is lost and flagged in `overlap_err`; upstream must not issue it.

## Timing
- All outputs are registered.
- The first `wr_en` appears 1 cycle after `win_start`.
- Throughput is 1 address per unstalled cycle.
- A window of length L with no stall occupies exactly L cycles; `win_done` is asserted in cycle L.
- Reset: state = IDLE and every output = 0 (`wr_en`, `wr_addr`, `win_done`, `busy`, `overlap_err`); internal A/R/G/counter = 0.
- Reset mid-window aborts the window immediately; no further writes occur.
- `busy` = 1 from the cycle after an accepted start through the cycle carrying `win_done`.

## Structure
- Shared package holds `DATA_ADDR_W`, `WIN_LEN_W` and the maximum K (6144), so the Le init-address save stage and this block stay consistent.
- One natural sub-module, `qpp_mod_add`: combinational (x + y) mod K, instantiated twice (R path and G path).
- Everything else is flat: FSM, counter and output registers.

## Test plan
- Interleaved order: K=40, `f2x2`=20, Rf=0, Rg=13, L=5, il_mode=1 -> `wr_addr` 0, 13, 6, 19, 12 on consecutive cycles; `win_done` with 12.
- Natural order: A=100, L=4, il_mode=0 -> `wr_addr` 100, 101, 102, 103 on consecutive cycles; `busy` drops the cycle after the last address.
- Back-to-back windows: second `win_start` (A=200) on the last address of the first -> continuous `wr_en`, 103 followed directly by 200, no gap, `overlap_err` stays 0.
- Stall: `stall` high for 3 cycles after the 2nd address of the K=40 case -> `wr_en` = 0 and `wr_addr` held at 13 during the stall, then 6, 19, 12; total 8 cycles.
- Edge and error cases: L=0 -> one `win_done` pulse with no writes. `win_start` in the 2nd cycle of a running window -> `overlap_err` = 1 and the window completes unchanged. K=6144 with R and G near K−1 -> results stay < K.
- Reset: assert `reset` low in the middle of a 64-long window -> all outputs 0 at once; a fresh `win_start` afterwards behaves exactly as the first window after power-up.
